// File: rtl/sprite_loader_pkg.sv
// Shared types and geometry for the sprite RAM write-side loader.
// Opcodes, FSM states and sprite dimensions live here so the loader and its bench agree.
package sprite_loader_pkg;

    typedef enum logic [1:0] {
        OP_ROW   = 2'b00,
        OP_FILL  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        FILL,
        CLEAR,
        FINISH
    } state_t;

    localparam int         H_SIZE   = 16;
    localparam int         V_SIZE   = 16;
    localparam logic [1:0] KEY_CODE = 2'b00;

endpackage

// File: rtl/sprite_ram_loader.sv
// Serialises row-write, sprite-fill and clear-all commands into one sprite RAM write per clock.
// RAM address layout is {sid, row[3:0], col[3:0]}; all outputs except cmd_ready are registered.
module sprite_ram_loader
    import sprite_loader_pkg::*;
#(
    parameter  int ADDR  = 10,
    localparam int SID_W = ADDR - 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SID_W-1:0] cmd_sid,
    input  logic [3:0]       cmd_row,
    input  logic [31:0]      cmd_data,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [ADDR-1:0]  addr_w,
    output logic [1:0]       pixel_out
);

    localparam logic [3:0] COL_LAST = 4'(H_SIZE - 1);
    localparam logic [7:0] PIX_LAST = 8'(H_SIZE * V_SIZE - 1);

    state_t           state;
    logic [SID_W-1:0] sid_q;
    logic [3:0]       row_q;
    logic [31:0]      data_q;
    logic [ADDR-1:0]  idx;

    logic [3:0]       col_nxt;
    logic [7:0]       pix_nxt;
    logic [ADDR-1:0]  idx_nxt;

    // idx always holds the index of the write currently on the bus.
    assign col_nxt = idx[3:0] + 4'd1;
    assign pix_nxt = idx[7:0] + 8'd1;
    assign idx_nxt = idx + ADDR'(1);

    // Gated by reset_n so no command can be accepted on the edge that releases reset.
    assign cmd_ready = (state == IDLE) && reset_n;

    // NOTE: every register here is assigned with <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sid_q     <= '0;
            row_q     <= '0;
            data_q    <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        sid_q  <= cmd_sid;
                        row_q  <= cmd_row;
                        data_q <= cmd_data;
                        idx    <= '0;
                        case (op_t'(cmd_op))
                            OP_ROW: begin
                                state     <= ROW;
                                busy      <= 1'b1;
                                we        <= 1'b1;
                                addr_w    <= {cmd_sid, cmd_row, 4'd0};
                                pixel_out <= cmd_data[1:0];
                            end
                            OP_FILL: begin
                                state     <= FILL;
                                busy      <= 1'b1;
                                we        <= 1'b1;
                                addr_w    <= {cmd_sid, 8'd0};
                                pixel_out <= cmd_data[1:0];
                            end
                            OP_CLEAR: begin
                                state     <= CLEAR;
                                busy      <= 1'b1;
                                we        <= 1'b1;
                                addr_w    <= '0;
                                pixel_out <= KEY_CODE;
                            end
                            default: begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                ROW: begin
                    if (idx[3:0] == COL_LAST) begin
                        state <= FINISH;
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx       <= idx_nxt;
                        addr_w    <= {sid_q, row_q, col_nxt};
                        pixel_out <= data_q[{col_nxt, 1'b0} +: 2];
                    end
                end
                FILL: begin
                    if (idx[7:0] == PIX_LAST) begin
                        state <= FINISH;
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx    <= idx_nxt;
                        addr_w <= {sid_q, pix_nxt};
                    end
                end
                CLEAR: begin
                    if (idx == '1) begin
                        state <= FINISH;
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx    <= idx_nxt;
                        addr_w <= idx_nxt;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Scoreboard bench for sprite_ram_loader: the driver queues the expected write/done timeline
// of each accepted command, and a negedge monitor compares it against the RAM port.
module tb_sprite_ram_loader;
    import sprite_loader_pkg::*;

    localparam int ADDR  = 10;
    localparam int SID_W = ADDR - 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [SID_W-1:0] cmd_sid = '0;
    logic [3:0]       cmd_row = 4'd0;
    logic [31:0]      cmd_data = 32'd0;
    logic             busy;
    logic             done;
    logic             we;
    logic [ADDR-1:0]  addr_w;
    logic [1:0]       pixel_out;

    always #5 clk = ~clk;

    sprite_ram_loader #(.ADDR(ADDR)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sid   (cmd_sid),
        .cmd_row   (cmd_row),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .we        (we),
        .addr_w    (addr_w),
        .pixel_out (pixel_out)
    );

    typedef struct {
        int              cyc;
        logic [ADDR-1:0] addr;
        logic [1:0]      pix;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  busy_lo = 0;
    int  busy_hi = -1;
    int  writes_seen = 0;
    int  next_free = 0;
    wr_t mon_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every visible write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (we) begin
                writes_seen++;
                if (wq.size() == 0) begin
                    check("unexpected_we", 32'd1, 32'd0);
                end else begin
                    mon_w = wq.pop_front();
                    check("wr_cycle", cyc, mon_w.cyc);
                    check("wr_addr", 32'(addr_w), 32'(mon_w.addr));
                    check("wr_pix", 32'(pixel_out), 32'(mon_w.pix));
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                check("missing_we", 32'd0, 32'd1);
                void'(wq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("done_cycle", cyc, dq.pop_front());
            end else if (dq.size() > 0 && dq[0] <= cyc) begin
                check("missing_done", 32'd0, 32'd1);
                void'(dq.pop_front());
            end
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Drives one command, holding cmd_valid until accepted, then queues its expected timeline.
    task automatic issue(input logic [1:0] op, input logic [SID_W-1:0] sid,
                         input logic [3:0] row, input logic [31:0] data);
        int  waited = 0;
        bit  held = 0;
        int  e;
        int  n;
        wr_t w;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sid   = sid;
        cmd_row   = row;
        cmd_data  = data;
        while (!cmd_ready) begin
            held = 1;
            @(negedge clk);
            waited++;
            if (waited > 3000) begin
                check("accept_timeout", 32'd0, 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        e = cyc + 1;
        if (held) check("accept_edge", e, next_free);
        else check("accept_not_early", 32'(e >= next_free), 32'd1);
        case (op)
            2'b00:   n = H_SIZE;
            2'b01:   n = H_SIZE * V_SIZE;
            2'b10:   n = 1 << ADDR;
            default: n = 0;
        endcase
        for (int k = 0; k < n; k++) begin
            w.cyc = e + k;
            case (op)
                2'b00: begin
                    w.addr = ADDR'(int'(sid) * 256 + int'(row) * 16 + k);
                    w.pix  = 2'((data >> (2 * k)) & 32'd3);
                end
                2'b01: begin
                    w.addr = ADDR'(int'(sid) * 256 + k);
                    w.pix  = data[1:0];
                end
                default: begin
                    w.addr = ADDR'(k);
                    w.pix  = KEY_CODE;
                end
            endcase
            wq.push_back(w);
        end
        dq.push_back(e + n);
        if (n > 0) begin
            busy_lo = e;
            busy_hi = e + n - 1;
        end
        next_free = e + n + 2;
        @(negedge clk);
        // Latched copy must be used: scramble the inputs once the command is taken.
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_sid   = SID_W'($urandom);
        cmd_row   = 4'($urandom);
        cmd_data  = $urandom;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((wq.size() > 0 || dq.size() > 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(wq.size() + dq.size()), 32'd0);
    endtask

    initial begin
        int base;
        int guard;
        logic [1:0] rop;

        #1;
        check("rst_we", 32'(we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(addr_w), 32'd0);
        check("rst_pix", 32'(pixel_out), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        #22 reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_we", 32'(we), 32'd0);

        issue(2'b00, 2'd2, 4'd5, 32'hE4E4_E4E4);
        issue(2'b01, 2'd1, 4'd0, 32'h0000_0002);
        issue(2'b00, 2'd3, 4'd9, 32'h1B2C_3D4E);
        issue(2'b10, 2'd0, 4'd0, 32'hFFFF_FFFF);
        issue(2'b11, 2'd1, 4'd3, 32'h1234_5678);
        issue(2'b00, 2'd0, 4'd15, 32'hA5A5_5A5A);
        wait_drain();

        // Reset at the 100th write of a fill: abandon it, then a row must start cleanly.
        issue(2'b01, 2'd3, 4'd0, 32'h0000_0003);
        base = writes_seen;
        guard = 0;
        while (writes_seen < base + 100 && guard < 400) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reached_write_100", 32'(writes_seen - base), 32'd100);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd0);
        wq.delete();
        dq.delete();
        busy_hi = -1;
        next_free = 0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        issue(2'b00, 2'd1, 4'd7, 32'h3210_FEDC);
        wait_drain();

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: rop = 2'b00;
                5, 6, 7:       rop = 2'b01;
                default:       rop = 2'b11;
            endcase
            issue(rop, SID_W'($urandom), 4'($urandom), $urandom);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
